// File: rtl/template_pkg.sv
// template_pkg: shared constants for the template_core timing block.
// Holds default counter/divider sizes, the wrap/saturate mode selectors and
// the divider width used by template_tick_gen.
package template_pkg;

   // Default configuration of the timing block
   localparam int DEF_CNT_WIDTH = 16;
   localparam int DEF_TICK_DIV  = 10;

   // Counter overflow behaviour selectors for WRAP_MODE
   localparam int WRAP = 1;
   localparam int SAT  = 0;

   // Width of the tick divider; TICK_DIV must fit in 1 .. 2**DIV_W-1
   localparam int DIV_W = 16;

   // Terminal divider value: the divider restarts after reaching this
   function automatic logic [DIV_W-1:0] div_last(input int tick_div);
      return DIV_W'(tick_div - 1);
   endfunction

endpackage

// File: rtl/template_tick_gen.sv
// template_tick_gen: programmable divider producing a one-cycle tick every
// TICK_DIV enabled cycles, plus a heartbeat that toggles on each tick.
// Only instantiated when TEMPLATE_HEARTBEAT_EN is defined.
module template_tick_gen
   import template_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick,
   output logic heartbeat
);

   localparam logic [DIV_W-1:0] DIV_LAST = div_last(TICK_DIV);

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             hb_q, hb_d;

   // Next-state: clear drops the partial period but keeps the heartbeat phase
   always_comb begin
      div_d  = div_q;
      tick_d = 1'b0;
      hb_d   = hb_q;
      if (clr) begin
         div_d = '0;
      end else if (en) begin
         if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
            hb_d   = ~hb_q;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q  <= '0;
         tick_q <= 1'b0;
         hb_q   <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
         hb_q   <= hb_d;
      end
   end

   assign tick      = tick_q;
   assign heartbeat = hb_q;

endmodule

// File: rtl/template_core.sv
// template_core: free-running enabled-cycle counter with wrap pulse or sticky
// saturation flag, and an optional tick/heartbeat generator.
// Macro TEMPLATE_HEARTBEAT_EN builds the divider/heartbeat; without it,
// tick and heartbeat are tied low.
module template_core
   import template_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH,
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int WRAP_MODE = WRAP
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic                 tick,
   output logic                 heartbeat,
   output logic                 wrap,
   output logic                 sat
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_PEN = CNT_MAX - 1'b1;

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 wrap_q, wrap_d;
   logic                 sat_q, sat_d;

   // Counter next-state: clear beats enable; overflow either wraps or pins
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      sat_d  = sat_q;
      if (clr) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (en) begin
         if (cnt_q == CNT_MAX) begin
            if (WRAP_MODE == WRAP) begin
               cnt_d  = '0;
               wrap_d = 1'b1;
            end else begin
               sat_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
            // Flag saturation on the edge that first reaches all-ones
            if ((WRAP_MODE == SAT) && (cnt_q == CNT_PEN)) begin
               sat_d = 1'b1;
            end
         end
      end
   end

   // Counter and flag registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         sat_q  <= sat_d;
      end
   end

   assign cycle_count = cnt_q;
   assign wrap        = wrap_q;
   assign sat         = sat_q;

`ifdef TEMPLATE_HEARTBEAT_EN
   template_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .clr       (clr),
      .tick      (tick),
      .heartbeat (heartbeat)
   );
`else
   assign tick      = 1'b0;
   assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_template_core.sv
// tb_template_core: directed bench for template_core. Three instances share
// the stimulus: 16-bit/div-10 wrapping, 4-bit/div-1 wrapping, 4-bit/div-3
// saturating. Expected values come from the enabled-edge count since the
// last reset/clear. Tick/heartbeat expectations follow TEMPLATE_HEARTBEAT_EN.
module tb_template_core;
   import template_pkg::*;

`ifdef TEMPLATE_HEARTBEAT_EN
   localparam bit HB_ON = 1'b1;
`else
   localparam bit HB_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, en, clr;

   logic [15:0] m_cnt;
   logic        m_tick, m_hb, m_wrap, m_sat;
   logic [3:0]  w_cnt;
   logic        w_tick, w_hb, w_wrap, w_sat;
   logic [3:0]  s_cnt;
   logic        s_tick, s_hb, s_wrap, s_sat;

   template_core #(.CNT_WIDTH(16), .TICK_DIV(10), .WRAP_MODE(WRAP)) u_main (
      .clk(clk), .reset(reset), .en(en), .clr(clr),
      .cycle_count(m_cnt), .tick(m_tick), .heartbeat(m_hb),
      .wrap(m_wrap), .sat(m_sat));

   template_core #(.CNT_WIDTH(4), .TICK_DIV(1), .WRAP_MODE(WRAP)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .clr(clr),
      .cycle_count(w_cnt), .tick(w_tick), .heartbeat(w_hb),
      .wrap(w_wrap), .sat(w_sat));

   template_core #(.CNT_WIDTH(4), .TICK_DIV(3), .WRAP_MODE(SAT)) u_sat (
      .clk(clk), .reset(reset), .en(en), .clr(clr),
      .cycle_count(s_cnt), .tick(s_tick), .heartbeat(s_hb),
      .wrap(s_wrap), .sat(s_sat));

   int n_checks = 0;
   int n_fail   = 0;
   int step_no  = 0;
   int e        = 0;     // enabled edges since last reset/clear
   bit last_en  = 1'b0;  // last edge was an enabled count edge
   bit hb_m = 1'b0, hb_w = 1'b0, hb_s = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got %0d expected %0d", step_no, tag, got, exp);
      end
   endtask

   task automatic step(input bit r, input bit c, input bit ein);
      reset = r;
      clr   = c;
      en    = ein;
      @(posedge clk);
      if (r) begin
         e = 0; last_en = 1'b0;
         hb_m = 1'b0; hb_w = 1'b0; hb_s = 1'b0;
      end else if (c) begin
         e = 0; last_en = 1'b0;
      end else if (ein) begin
         e++; last_en = 1'b1;
         if (e % 10 == 0) hb_m = ~hb_m;
         hb_w = ~hb_w;
         if (e % 3 == 0) hb_s = ~hb_s;
      end else begin
         last_en = 1'b0;
      end
      #1;
      step_no++;
      $display("step %0d rst=%0b clr=%0b en=%0b | main cnt=%0d tick=%0b hb=%0b | w4 cnt=%0d wrap=%0b | s4 cnt=%0d sat=%0b",
               step_no, r, c, ein, m_cnt, m_tick, m_hb, w_cnt, w_wrap, s_cnt, s_sat);
      check("main_cnt",  32'(m_cnt),  32'(e % 65536));
      check("main_tick", 32'(m_tick), 32'(HB_ON && last_en && (e % 10 == 0)));
      check("main_hb",   32'(m_hb),   32'(HB_ON && hb_m));
      check("main_wrap", 32'(m_wrap), 32'(0));
      check("main_sat",  32'(m_sat),  32'(0));
      check("w4_cnt",    32'(w_cnt),  32'(e % 16));
      check("w4_wrap",   32'(w_wrap), 32'(last_en && (e % 16 == 0)));
      check("w4_sat",    32'(w_sat),  32'(0));
      check("w4_tick",   32'(w_tick), 32'(HB_ON && last_en));
      check("w4_hb",     32'(w_hb),   32'(HB_ON && hb_w));
      check("s4_cnt",    32'(s_cnt),  32'((e > 15) ? 15 : e));
      check("s4_sat",    32'(s_sat),  32'(e >= 15));
      check("s4_wrap",   32'(s_wrap), 32'(0));
      check("s4_tick",   32'(s_tick), 32'(HB_ON && last_en && (e % 3 == 0)));
      check("s4_hb",     32'(s_hb),   32'(HB_ON && hb_s));
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b1;
      clr   = 1'b0;
      // Reset held with enable high: everything stays zero
      repeat (3) step(1'b1, 1'b0, 1'b1);
      // Count from release: ticks at 10/20/30, wrap at 16, saturation at 15
      repeat (30) step(1'b0, 1'b0, 1'b1);
      // Clear together with enable: clear wins
      step(1'b0, 1'b1, 1'b1);
      // Enable gating 1,0,1,0...: four counts, no tick
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, (i % 2 == 0));
      // Run on into saturation of the 4-bit saturating instance
      repeat (20) step(1'b0, 1'b0, 1'b1);
      // Clear drops count and sticky sat
      step(1'b0, 1'b1, 1'b0);
      // Clear mid-period with enable high, then a full period to next tick
      repeat (7) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      repeat (10) step(1'b0, 1'b0, 1'b1);
      // Bring the 4-bit wrapping counter to 15, then clear instead of wrapping
      repeat (5) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      // Reset mid-run returns heartbeat to 0, then restart counting
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
